// File: rtl/shader_sequencer.sv
// shader_sequencer: frame-level initiator for pixel_shader.
// Walks every (row, col) in raster order. For each position it streams the voxel list
// through the rasterize handshake, then requests a shade, then writes the shaded pixel
// to the frame-buffer port. A frame runs from a one-cycle start to a one-cycle frame_done.
module shader_sequencer #(
   parameter int unsigned ROW_BITS     = 8,
   parameter int unsigned COL_BITS     = 8,
   parameter int unsigned COORD_BITS   = 8,
   parameter int unsigned PALETTE_BITS = 8,
   parameter int unsigned FRAC_BITS    = 8,
   parameter int unsigned PIXEL_BITS   = 8,
   parameter int unsigned VADDR_BITS   = 10,
   parameter int unsigned NUM_ROWS     = 240,
   parameter int unsigned NUM_COLS     = 256
) (
   input  logic                                  clock,
   input  logic                                  reset,
   input  logic                                  start,
   input  logic [VADDR_BITS:0]                   num_voxels,
   input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_in_x,
   input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_in_y,
   input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_in_z,
   input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_in_x,
   input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_in_y,
   input  logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_in_z,
   output logic                                  busy,
   output logic                                  frame_done,
   output logic                                  voxel_rd,
   output logic [VADDR_BITS-1:0]                 voxel_addr,
   input  logic [PALETTE_BITS+3*COORD_BITS-1:0]  voxel_rdata,
   output logic                                  palette_rd,
   output logic [PALETTE_BITS-1:0]               palette_addr,
   input  logic [PIXEL_BITS-1:0]                 palette_rdata,
   output logic                                  do_rasterize,
   output logic                                  do_shade,
   output logic [COORD_BITS-1:0]                 voxel_x,
   output logic [COORD_BITS-1:0]                 voxel_y,
   output logic [COORD_BITS-1:0]                 voxel_z,
   output logic [PALETTE_BITS-1:0]               voxel_id,
   output logic [PIXEL_BITS-1:0]                 palette_entry,
   output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_x,
   output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_y,
   output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_pos_z,
   output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_x,
   output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_y,
   output logic signed [COORD_BITS+FRAC_BITS-1:0] cam_look_z,
   output logic [ROW_BITS-1:0]                   row,
   output logic [COL_BITS-1:0]                   col,
   input  logic                                  rasterizing_done,
   input  logic                                  shading_done,
   input  logic [PIXEL_BITS-1:0]                 pixel,
   output logic                                  fb_we,
   output logic [ROW_BITS-1:0]                   fb_row,
   output logic [COL_BITS-1:0]                   fb_col,
   output logic [PIXEL_BITS-1:0]                 fb_wdata
);

   localparam int unsigned CamBits = COORD_BITS + FRAC_BITS;
   localparam int unsigned CntBits = VADDR_BITS + 1;
   localparam logic [ROW_BITS-1:0] LastRow = ROW_BITS'(NUM_ROWS - 1);
   localparam logic [COL_BITS-1:0] LastCol = COL_BITS'(NUM_COLS - 1);

   typedef enum logic [3:0] {
      StIdle,
      StFetch,
      StPal,
      StLoad,
      StRast,
      StRastRel,
      StShade,
      StShadeRel,
      StWrite,
      StAdv
   } state_e;

   state_e                   state_q, state_d;
   logic [CntBits-1:0]       vidx_q, vidx_d;
   logic [CntBits-1:0]       num_voxels_q;
   logic [ROW_BITS-1:0]      row_q, row_d;
   logic [COL_BITS-1:0]      col_q, col_d;
   logic [COORD_BITS-1:0]    voxel_x_q, voxel_y_q, voxel_z_q;
   logic [PALETTE_BITS-1:0]  voxel_id_q;
   logic [PIXEL_BITS-1:0]    palette_entry_q;
   logic [PIXEL_BITS-1:0]    fb_wdata_q;
   logic signed [CamBits-1:0] cam_pos_x_q, cam_pos_y_q, cam_pos_z_q;
   logic signed [CamBits-1:0] cam_look_x_q, cam_look_y_q, cam_look_z_q;
   logic                     accept;
   logic [PALETTE_BITS-1:0]  rdata_id;

   assign accept   = (state_q == StIdle) && start;
   assign rdata_id = voxel_rdata[PALETTE_BITS+3*COORD_BITS-1 -: PALETTE_BITS];

   // Next-state, position counters and one-cycle strobes
   always_comb begin
      state_d      = state_q;
      vidx_d       = vidx_q;
      row_d        = row_q;
      col_d        = col_q;
      voxel_rd     = 1'b0;
      palette_rd   = 1'b0;
      do_rasterize = 1'b0;
      do_shade     = 1'b0;
      fb_we        = 1'b0;
      frame_done   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               vidx_d  = '0;
               row_d   = '0;
               col_d   = '0;
               state_d = (num_voxels == '0) ? StShade : StFetch;
            end
         end
         StFetch: begin
            voxel_rd = 1'b1;
            state_d  = StPal;
         end
         StPal: begin
            palette_rd = 1'b1;
            state_d    = StLoad;
         end
         StLoad: begin
            state_d = StRast;
         end
         StRast: begin
            do_rasterize = 1'b1;
            if (rasterizing_done) begin
               state_d = StRastRel;
            end
         end
         StRastRel: begin
            // The next request is only issued once the shader has released its done.
            if (!rasterizing_done) begin
               vidx_d  = vidx_q + CntBits'(1);
               state_d = (vidx_d < num_voxels_q) ? StFetch : StShade;
            end
         end
         StShade: begin
            do_shade = 1'b1;
            if (shading_done) begin
               state_d = StShadeRel;
            end
         end
         StShadeRel: begin
            if (!shading_done) begin
               state_d = StWrite;
            end
         end
         StWrite: begin
            fb_we   = 1'b1;
            state_d = StAdv;
         end
         StAdv: begin
            vidx_d  = '0;
            state_d = (num_voxels_q == '0) ? StShade : StFetch;
            if (col_q != LastCol) begin
               col_d = col_q + COL_BITS'(1);
            end else if (row_q != LastRow) begin
               col_d = '0;
               row_d = row_q + ROW_BITS'(1);
            end else begin
               // Last pixel: row/col keep their final values until the next start.
               frame_done = 1'b1;
               state_d    = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State and position registers
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         vidx_q  <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         vidx_q  <= vidx_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   // Frame parameters, fetched operands and shaded result capture
   always_ff @(posedge clock) begin
      if (reset) begin
         num_voxels_q    <= '0;
         cam_pos_x_q     <= '0;
         cam_pos_y_q     <= '0;
         cam_pos_z_q     <= '0;
         cam_look_x_q    <= '0;
         cam_look_y_q    <= '0;
         cam_look_z_q    <= '0;
         voxel_x_q       <= '0;
         voxel_y_q       <= '0;
         voxel_z_q       <= '0;
         voxel_id_q      <= '0;
         palette_entry_q <= '0;
         fb_wdata_q      <= '0;
      end else begin
         if (accept) begin
            num_voxels_q <= num_voxels;
            cam_pos_x_q  <= cam_pos_in_x;
            cam_pos_y_q  <= cam_pos_in_y;
            cam_pos_z_q  <= cam_pos_in_z;
            cam_look_x_q <= cam_look_in_x;
            cam_look_y_q <= cam_look_in_y;
            cam_look_z_q <= cam_look_in_z;
         end
         if (state_q == StPal) begin
            {voxel_id_q, voxel_z_q, voxel_y_q, voxel_x_q} <= voxel_rdata;
         end
         if (state_q == StLoad) begin
            palette_entry_q <= palette_rdata;
         end
         if ((state_q == StShade) && shading_done) begin
            fb_wdata_q <= pixel;
         end
      end
   end

   // Addresses are gated so the RAM ports read as zero whenever no read is issued.
   assign voxel_addr    = voxel_rd ? vidx_q[VADDR_BITS-1:0] : '0;
   assign palette_addr  = palette_rd ? rdata_id : '0;
   assign busy          = (state_q != StIdle);
   assign voxel_x       = voxel_x_q;
   assign voxel_y       = voxel_y_q;
   assign voxel_z       = voxel_z_q;
   assign voxel_id      = voxel_id_q;
   assign palette_entry = palette_entry_q;
   assign cam_pos_x     = cam_pos_x_q;
   assign cam_pos_y     = cam_pos_y_q;
   assign cam_pos_z     = cam_pos_z_q;
   assign cam_look_x    = cam_look_x_q;
   assign cam_look_y    = cam_look_y_q;
   assign cam_look_z    = cam_look_z_q;
   assign row           = row_q;
   assign col           = col_q;
   assign fb_row        = row_q;
   assign fb_col        = col_q;
   assign fb_wdata      = fb_wdata_q;

endmodule

// File: tb/tb_shader_sequencer.sv
// Bench for shader_sequencer: voxel/palette RAMs, a shader with random handshake
// latency, and a monitor that logs RAM reads, requests and frame-buffer writes.
module tb_shader_sequencer;
   localparam int NR   = 2;
   localparam int NC   = 3;
   localparam int NPIX = NR * NC;

   logic clock = 1'b0;
   logic reset;
   logic start;
   logic [10:0] num_voxels;
   logic signed [15:0] cam_pos_in_x, cam_pos_in_y, cam_pos_in_z;
   logic signed [15:0] cam_look_in_x, cam_look_in_y, cam_look_in_z;
   logic busy, frame_done, voxel_rd, palette_rd, do_rasterize, do_shade;
   logic [9:0] voxel_addr;
   logic [31:0] voxel_rdata;
   logic [7:0] palette_addr, palette_rdata;
   logic [7:0] voxel_x, voxel_y, voxel_z, voxel_id, palette_entry;
   logic signed [15:0] cam_pos_x, cam_pos_y, cam_pos_z, cam_look_x, cam_look_y, cam_look_z;
   logic [7:0] row, col;
   logic rasterizing_done, shading_done;
   logic [7:0] pixel;
   logic fb_we;
   logic [7:0] fb_row, fb_col, fb_wdata;

   int vectors = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   shader_sequencer #(.NUM_ROWS(NR), .NUM_COLS(NC)) dut (
      .clock(clock), .reset(reset), .start(start), .num_voxels(num_voxels),
      .cam_pos_in_x(cam_pos_in_x), .cam_pos_in_y(cam_pos_in_y), .cam_pos_in_z(cam_pos_in_z),
      .cam_look_in_x(cam_look_in_x), .cam_look_in_y(cam_look_in_y),
      .cam_look_in_z(cam_look_in_z),
      .busy(busy), .frame_done(frame_done), .voxel_rd(voxel_rd), .voxel_addr(voxel_addr),
      .voxel_rdata(voxel_rdata), .palette_rd(palette_rd), .palette_addr(palette_addr),
      .palette_rdata(palette_rdata), .do_rasterize(do_rasterize), .do_shade(do_shade),
      .voxel_x(voxel_x), .voxel_y(voxel_y), .voxel_z(voxel_z), .voxel_id(voxel_id),
      .palette_entry(palette_entry),
      .cam_pos_x(cam_pos_x), .cam_pos_y(cam_pos_y), .cam_pos_z(cam_pos_z),
      .cam_look_x(cam_look_x), .cam_look_y(cam_look_y), .cam_look_z(cam_look_z),
      .row(row), .col(col), .rasterizing_done(rasterizing_done),
      .shading_done(shading_done), .pixel(pixel),
      .fb_we(fb_we), .fb_row(fb_row), .fb_col(fb_col), .fb_wdata(fb_wdata)
   );

   logic [255:0] all_outs;
   assign all_outs = 256'({busy, frame_done, voxel_rd, voxel_addr, palette_rd, palette_addr,
                           do_rasterize, do_shade, voxel_x, voxel_y, voxel_z, voxel_id,
                           palette_entry, cam_pos_x, cam_pos_y, cam_pos_z, cam_look_x,
                           cam_look_y, cam_look_z, row, col, fb_we, fb_row, fb_col, fb_wdata});

   // RAMs: data valid only the cycle after a read, garbage otherwise
   logic [31:0] vram [0:1023];
   logic [7:0]  pal  [0:255];
   always @(posedge clock) begin
      if (voxel_rd) voxel_rdata <= vram[voxel_addr];
      else voxel_rdata <= 32'($urandom);
      if (palette_rd) palette_rdata <= pal[palette_addr];
      else palette_rdata <= 8'($urandom);
   end

   // Shader: folds each rasterized voxel into acc; shade returns acc ^ (row*7+col)
   int unsigned dly_min = 0, dly_max = 3, hold_min = 0, hold_max = 2;
   bit stall = 1'b0;
   int unsigned acc, r_wait, r_hold, s_wait, s_hold;
   always @(posedge clock) begin
      if (reset) begin
         rasterizing_done <= 1'b0;
         shading_done     <= 1'b0;
         pixel            <= 8'h00;
         acc    = 0;
         r_wait = $urandom_range(dly_max, dly_min);
         s_wait = $urandom_range(dly_max, dly_min);
         r_hold = 0;
         s_hold = 0;
      end else begin
         if (do_rasterize && !rasterizing_done && !stall) begin
            if (r_wait == 0) begin
               rasterizing_done <= 1'b1;
               acc = acc * 3 + 32'(voxel_x) + 32'(voxel_y) + 32'(voxel_z) + 32'(voxel_id)
                     + 32'(palette_entry);
               r_hold = $urandom_range(hold_max, hold_min);
            end else r_wait--;
         end else if (!do_rasterize && rasterizing_done) begin
            if (r_hold == 0) begin
               rasterizing_done <= 1'b0;
               r_wait = $urandom_range(dly_max, dly_min);
            end else r_hold--;
         end
         if (do_shade && !shading_done && !stall) begin
            if (s_wait == 0) begin
               shading_done <= 1'b1;
               pixel <= 8'(acc ^ (32'(row) * 7 + 32'(col)));
               acc = 0;
               s_hold = $urandom_range(hold_max, hold_min);
            end else s_wait--;
         end else if (!do_shade && shading_done) begin
            if (s_hold == 0) begin
               shading_done <= 1'b0;
               pixel <= 8'($urandom);
               s_wait = $urandom_range(dly_max, dly_min);
            end else s_hold--;
         end
      end
   end

   // Monitor: logs transactions for the test tasks to inspect
   int unsigned cyc = 0, last_we = 0, rises = 0, dup_viol = 0, shade_reqs = 0;
   logic prev_rast = 1'b0, prev_shade = 1'b0;
   int addr_q[$];
   logic [23:0] we_q[$];
   int rise_q[$];
   int fd_q[$];
   always @(posedge clock) begin
      cyc++;
      if (reset) begin
         rises = 0;
      end else begin
         if (do_rasterize && !prev_rast) begin
            rises++;
            if (rasterizing_done) dup_viol++;
         end
         if (do_shade && !prev_shade) shade_reqs++;
         if (voxel_rd) addr_q.push_back(int'(voxel_addr));
         if (fb_we) begin
            we_q.push_back({fb_row, fb_col, fb_wdata});
            rise_q.push_back(int'(rises));
            rises = 0;
            last_we = cyc;
         end
         if (frame_done) fd_q.push_back(int'(cyc - last_we));
      end
      prev_rast  = do_rasterize;
      prev_shade = do_shade;
   end

   // Reference: pixel at (r,c) given the first n voxels of vram
   function automatic logic [7:0] exp_pixel(int n, int r, int c);
      int unsigned a;
      logic [31:0] w;
      a = 0;
      for (int i = 0; i < n; i++) begin
         w = vram[i];
         a = a * 3 + 32'(w[7:0]) + 32'(w[15:8]) + 32'(w[23:16]) + 32'(w[31:24])
             + 32'(pal[w[31:24]]);
      end
      return 8'(a ^ 32'(r * 7 + c));
   endfunction

   task automatic load_scene();
      for (int i = 0; i < 16; i++) vram[i] = $urandom;
      for (int i = 0; i < 256; i++) pal[i] = 8'($urandom);
   endtask

   task automatic set_cam(output logic [95:0] cam);
      cam_pos_in_x  = 16'($urandom);
      cam_pos_in_y  = 16'($urandom);
      cam_pos_in_z  = 16'($urandom);
      cam_look_in_x = 16'($urandom);
      cam_look_in_y = 16'($urandom);
      cam_look_in_z = 16'($urandom);
      cam = {cam_pos_in_x, cam_pos_in_y, cam_pos_in_z, cam_look_in_x, cam_look_in_y,
             cam_look_in_z};
   endtask

   task automatic start_frame(input int n);
      @(negedge clock);
      num_voxels = 11'(n);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic wait_frame(input int fd_base, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clock);
         if (fd_q.size() > fd_base) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_rast(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (do_rasterize) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; num_voxels = '0;
      cam_pos_in_x = '0; cam_pos_in_y = '0; cam_pos_in_z = '0;
      cam_look_in_x = '0; cam_look_in_y = '0; cam_look_in_z = '0;
      repeat (3) @(negedge clock);
      vectors++;
      if (all_outs !== '0) begin
         miscompares++; $display("FAIL reset_outputs: got %h want 0", all_outs);
      end
      reset = 1'b0;
      repeat (3) @(negedge clock);
      vectors++;
      if ({busy, voxel_rd, do_rasterize, do_shade, fb_we} !== 5'b0) begin
         miscompares++; $display("FAIL reset_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_single_voxel();
      logic [95:0] cam;
      bit ok;
      int wb, fb;
      load_scene();
      vram[0] = 32'h0100_0000;
      pal[1]  = 8'hff;
      dly_min = 2; dly_max = 2; hold_min = 0; hold_max = 0;
      wb = we_q.size(); fb = fd_q.size();
      set_cam(cam);
      start_frame(1);
      wait_rast(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL single_rast_timeout: got none want 1"); end
      vectors++;
      if ({voxel_id, palette_entry, voxel_x, voxel_y, voxel_z} !== 40'h01ff000000) begin
         miscompares++;
         $display("FAIL single_operands: got id=%h pal=%h want id=01 pal=ff", voxel_id,
                  palette_entry);
      end
      wait_frame(fb, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL single_frame_timeout: got none want 1"); end
      vectors++;
      if (we_q.size() - wb !== NPIX) begin
         miscompares++;
         $display("FAIL single_write_count: got %0d want %0d", we_q.size() - wb, NPIX);
      end
      for (int p = 0; p < NPIX && wb + p < we_q.size(); p++) begin
         logic [23:0] want;
         want = {8'(p / NC), 8'(p % NC), exp_pixel(1, p / NC, p % NC)};
         vectors++;
         if (we_q[wb + p] !== want) begin
            miscompares++; $display("FAIL single_write[%0d]: got %h want %h", p, we_q[wb + p], want);
         end
      end
      vectors++;
      if (fd_q.size() > fb && fd_q[fb] !== 1) begin
         miscompares++; $display("FAIL single_done_gap: got %0d want 1", fd_q[fb]);
      end
   endtask

   task automatic test_multi_voxel();
      logic [95:0] cam;
      bit ok;
      int wb, fb, ab, rb, db;
      load_scene();
      dly_min = 0; dly_max = 3; hold_min = 0; hold_max = 2;
      wb = we_q.size(); fb = fd_q.size(); ab = addr_q.size(); rb = rise_q.size();
      db = int'(dup_viol);
      set_cam(cam);
      start_frame(3);
      wait_frame(fb, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL multi_frame_timeout: got none want 1"); end
      vectors++;
      if (addr_q.size() - ab !== NPIX * 3) begin
         miscompares++;
         $display("FAIL multi_read_count: got %0d want %0d", addr_q.size() - ab, NPIX * 3);
      end
      for (int i = 0; i < NPIX * 3 && ab + i < addr_q.size(); i++) begin
         vectors++;
         if (addr_q[ab + i] !== i % 3) begin
            miscompares++;
            $display("FAIL multi_addr[%0d]: got %0d want %0d", i, addr_q[ab + i], i % 3);
         end
      end
      for (int p = 0; p < NPIX && wb + p < we_q.size(); p++) begin
         logic [23:0] want;
         want = {8'(p / NC), 8'(p % NC), exp_pixel(3, p / NC, p % NC)};
         vectors++;
         if (we_q[wb + p] !== want || rise_q[rb + p] !== 3) begin
            miscompares++;
            $display("FAIL multi_pixel[%0d]: got %h/%0d reqs want %h/3 reqs", p, we_q[wb + p],
                     rise_q[rb + p], want);
         end
      end
      vectors++;
      if (int'(dup_viol) - db !== 0) begin
         miscompares++; $display("FAIL multi_early_request: got %0d want 0", int'(dup_viol) - db);
      end
      vectors++;
      if ({busy, row, col} !== {1'b0, 8'(NR - 1), 8'(NC - 1)}) begin
         miscompares++;
         $display("FAIL multi_final_pos: got busy=%b %0d,%0d want 0 %0d,%0d", busy, row, col,
                  NR - 1, NC - 1);
      end
      vectors++;
      if ({cam_pos_x, cam_pos_y, cam_pos_z, cam_look_x, cam_look_y, cam_look_z} !== cam) begin
         miscompares++; $display("FAIL multi_camera: got %h want %h",
            {cam_pos_x, cam_pos_y, cam_pos_z, cam_look_x, cam_look_y, cam_look_z}, cam);
      end
   endtask

   task automatic test_zero_voxels();
      logic [95:0] cam;
      bit ok;
      int wb, fb, ab, sb;
      load_scene();
      wb = we_q.size(); fb = fd_q.size(); ab = addr_q.size(); sb = int'(shade_reqs);
      set_cam(cam);
      start_frame(0);
      wait_frame(fb, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL zero_frame_timeout: got none want 1"); end
      vectors++;
      if (addr_q.size() !== ab) begin
         miscompares++; $display("FAIL zero_voxel_reads: got %0d want 0", addr_q.size() - ab);
      end
      vectors++;
      if (int'(shade_reqs) - sb !== NPIX) begin
         miscompares++;
         $display("FAIL zero_shade_reqs: got %0d want %0d", int'(shade_reqs) - sb, NPIX);
      end
      for (int p = 0; p < NPIX && wb + p < we_q.size(); p++) begin
         logic [23:0] want;
         want = {8'(p / NC), 8'(p % NC), exp_pixel(0, p / NC, p % NC)};
         vectors++;
         if (we_q[wb + p] !== want) begin
            miscompares++; $display("FAIL zero_write[%0d]: got %h want %h", p, we_q[wb + p], want);
         end
      end
   endtask

   task automatic test_start_while_busy();
      logic [95:0] cam, cam2;
      bit ok;
      int wb, fb, rb;
      load_scene();
      wb = we_q.size(); fb = fd_q.size(); rb = rise_q.size();
      set_cam(cam);
      start_frame(2);
      repeat (15) @(negedge clock);
      set_cam(cam2);
      num_voxels = 11'd5;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      wait_frame(fb, ok);
      repeat (80) @(negedge clock);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL busy_frame_timeout: got none want 1"); end
      vectors++;
      if ({cam_pos_x, cam_pos_y, cam_pos_z, cam_look_x, cam_look_y, cam_look_z} !== cam) begin
         miscompares++; $display("FAIL busy_camera: got %h want %h",
            {cam_pos_x, cam_pos_y, cam_pos_z, cam_look_x, cam_look_y, cam_look_z}, cam);
      end
      vectors++;
      if (we_q.size() - wb !== NPIX || fd_q.size() - fb !== 1) begin
         miscompares++; $display("FAIL busy_counts: got %0d writes %0d dones want %0d 1",
                                 we_q.size() - wb, fd_q.size() - fb, NPIX);
      end
      for (int p = 0; p < NPIX && wb + p < we_q.size(); p++) begin
         logic [23:0] want;
         want = {8'(p / NC), 8'(p % NC), exp_pixel(2, p / NC, p % NC)};
         vectors++;
         if (we_q[wb + p] !== want || rise_q[rb + p] !== 2) begin
            miscompares++;
            $display("FAIL busy_pixel[%0d]: got %h/%0d reqs want %h/2 reqs", p, we_q[wb + p],
                     rise_q[rb + p], want);
         end
      end
   endtask

   task automatic test_long_hold();
      logic [95:0] cam;
      bit ok;
      int wb, fb, rb, db;
      load_scene();
      dly_min = 0; dly_max = 1; hold_min = 5; hold_max = 5;
      wb = we_q.size(); fb = fd_q.size(); rb = rise_q.size(); db = int'(dup_viol);
      set_cam(cam);
      start_frame(2);
      wait_frame(fb, ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL hold_frame_timeout: got none want 1"); end
      vectors++;
      if (int'(dup_viol) - db !== 0) begin
         miscompares++; $display("FAIL hold_early_request: got %0d want 0", int'(dup_viol) - db);
      end
      for (int p = 0; p < NPIX && wb + p < we_q.size(); p++) begin
         logic [23:0] want;
         want = {8'(p / NC), 8'(p % NC), exp_pixel(2, p / NC, p % NC)};
         vectors++;
         if (we_q[wb + p] !== want || rise_q[rb + p] !== 2) begin
            miscompares++;
            $display("FAIL hold_pixel[%0d]: got %h/%0d reqs want %h/2 reqs", p, we_q[wb + p],
                     rise_q[rb + p], want);
         end
      end
      hold_min = 0; hold_max = 2;
   endtask

   task automatic test_reset_mid_rast();
      logic [95:0] cam;
      bit ok;
      int wb;
      load_scene();
      stall = 1'b1;
      set_cam(cam);
      start_frame(2);
      wait_rast(ok);
      vectors++;
      if (!ok) begin miscompares++; $display("FAIL midrst_rast_timeout: got none want 1"); end
      reset = 1'b1;
      @(negedge clock);
      vectors++;
      if (all_outs !== '0) begin
         miscompares++; $display("FAIL midrst_outputs: got %h want 0", all_outs);
      end
      reset = 1'b0;
      stall = 1'b0;
      wb = we_q.size();
      repeat (20) @(negedge clock);
      vectors++;
      if (we_q.size() !== wb || busy !== 1'b0) begin
         miscompares++;
         $display("FAIL midrst_idle: got %0d writes busy=%b want 0 0", we_q.size() - wb, busy);
      end
   endtask

   task automatic test_random_frames();
      logic [95:0] cam;
      bit ok;
      int wb, fb, rb, n;
      for (int f = 0; f < 3; f++) begin
         load_scene();
         n = int'($urandom_range(4, 1));
         wb = we_q.size(); fb = fd_q.size(); rb = rise_q.size();
         set_cam(cam);
         start_frame(n);
         wait_frame(fb, ok);
         vectors++;
         if (!ok) begin miscompares++; $display("FAIL rand_frame_timeout[%0d]: got none want 1", f); end
         for (int p = 0; p < NPIX && wb + p < we_q.size(); p++) begin
            logic [23:0] want;
            want = {8'(p / NC), 8'(p % NC), exp_pixel(n, p / NC, p % NC)};
            vectors++;
            if (we_q[wb + p] !== want || rise_q[rb + p] !== n) begin
               miscompares++;
               $display("FAIL rand_pixel[%0d][%0d]: got %h/%0d want %h/%0d", f, p, we_q[wb + p],
                        rise_q[rb + p], want, n);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_voxel();
      test_multi_voxel();
      test_zero_voxels();
      test_start_while_busy();
      test_long_hold();
      test_reset_mid_rast();
      test_random_frames();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
